// File: rtl/nibble_add_pkg.sv
// Shared types and helpers for the nibble-serial adder.
// Optional SERIAL_ADD_OVF_EN build adds the signed-overflow path in the users of this package.
package nibble_add_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {IDLE, RUN, DONE} add_state_t;

    // Never returns zero, so a counter sized with it always has at least one bit.
    function automatic int clog2_safe(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/nibble_add4.sv
// Combinational 4-bit full-adder stage used once per clock by the serial adder.
// With SERIAL_ADD_OVF_EN defined it also exposes c_msb, the carry into bit 3.
module nibble_add4
    import nibble_add_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             c_in,
`ifdef SERIAL_ADD_OVF_EN
    output logic             c_msb,
`endif
    output logic [NIB_W-1:0] sum,
    output logic             c_out
);

    assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {{NIB_W{1'b0}}, c_in};

`ifdef SERIAL_ADD_OVF_EN
    logic [NIB_W-1:0] low_sum;

    assign low_sum = {1'b0, a[NIB_W-2:0]} + {1'b0, b[NIB_W-2:0]} + {{(NIB_W-1){1'b0}}, c_in};
    assign c_msb   = low_sum[NIB_W-1];
`endif

endmodule

// File: rtl/nibble_serial_adder.sv
// Wide adder that consumes one nibble per clock through a registered carry, valid/ready on both sides.
// Define SERIAL_ADD_OVF_EN to add the ovf_o two's-complement overflow output.
module nibble_serial_adder
    import nibble_add_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic [NIB_W*NIBBLES-1:0] a_i,
    input  logic [NIB_W*NIBBLES-1:0] b_i,
    input  logic                     c_in_i,
    output logic                     valid_o,
    input  logic                     ready_i,
`ifdef SERIAL_ADD_OVF_EN
    output logic                     ovf_o,
`endif
    output logic [NIB_W*NIBBLES-1:0] sum_o,
    output logic                     c_out_o
);

    localparam int W     = NIB_W * NIBBLES;
    localparam int CNT_W = clog2_safe(NIBBLES);

    add_state_t       state_q, state_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [W-1:0]     sum_q, sum_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [NIB_W-1:0] nib_sum;
    logic             nib_cout;
    logic             last_nib;

`ifdef SERIAL_ADD_OVF_EN
    logic ovf_q, ovf_d;
    logic nib_cmsb;
`endif

    nibble_add4 u_nib (
        .a     (a_q[NIB_W-1:0]),
        .b     (b_q[NIB_W-1:0]),
        .c_in  (carry_q),
`ifdef SERIAL_ADD_OVF_EN
        .c_msb (nib_cmsb),
`endif
        .sum   (nib_sum),
        .c_out (nib_cout)
    );

    assign last_nib = (cnt_q == CNT_W'(NIBBLES - 1));

    always_comb begin
        // NOTE: every *_d gets its hold value first, so no branch can leave one unassigned and infer a latch.
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
`ifdef SERIAL_ADD_OVF_EN
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (valid_i) begin
                    a_d     = a_i;
                    b_d     = b_i;
                    carry_d = c_in_i;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // New nibble enters at the top so the LSB nibble lands at bit 0 after the last step.
                sum_d   = {nib_sum, sum_q[W-1:NIB_W]};
                carry_d = nib_cout;
                a_d     = a_q >> NIB_W;
                b_d     = b_q >> NIB_W;
                cnt_d   = cnt_q + CNT_W'(1);
                if (last_nib) begin
                    state_d = DONE;
`ifdef SERIAL_ADD_OVF_EN
                    ovf_d   = nib_cmsb ^ nib_cout;
`endif
                end
            end
            DONE: begin
                if (ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state is written only here and only with <=, so every flop samples the pre-edge values.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign ready_o = (state_q == IDLE);
    assign valid_o = (state_q == DONE);
    assign sum_o   = sum_q;
    // After the final RUN edge the carry flop holds the carry out of the top nibble and is frozen in DONE.
    assign c_out_o = carry_q;
`ifdef SERIAL_ADD_OVF_EN
    assign ovf_o   = ovf_q;
`endif

endmodule
